// File: rtl/order_packet_assembler.sv
// Frames the raw UART order byte stream (SYNC, 4 payload bytes, XOR checksum)
// into 32-bit order words for the matching engine; bad or stalled frames are dropped and counted.
module order_packet_assembler #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [31:0] payload_data,
  output logic        packet_ready,
  output logic        reset_byte_count_pulse,
  output logic        checksum_error,
  output logic        timeout_error,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  // Compare against LAST so the abort lands exactly TIMEOUT_CYCLES idle edges after the last byte.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] shift_q, shift_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] payload_q, payload_d;
  logic        pr_q, pr_d;
  logic        rbc_q, rbc_d;
  logic        ce_q, ce_d;
  logic        te_q, te_d;
  logic [7:0]  err_q, err_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    xor_d     = xor_q;
    tmo_d     = tmo_q;
    payload_d = payload_q;
    err_d     = err_q;
    pr_d      = 1'b0;
    rbc_d     = 1'b0;
    ce_d      = 1'b0;
    te_d      = 1'b0;
    case (state_q)
      HUNT: begin
        tmo_d = 16'd0;
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = PAYLOAD;
          idx_d   = 2'd0;
          shift_d = 32'd0;
          xor_d   = 8'd0;
        end
      end
      PAYLOAD, CHECK: begin
        if (rx_valid) begin
          tmo_d = 16'd0;
          if (state_q == PAYLOAD) begin
            shift_d = {shift_q[23:0], rx_byte};
            xor_d   = xor_q ^ rx_byte;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = CHECK;
          end else begin
            rbc_d   = 1'b1;
            state_d = HUNT;
            if (rx_byte == xor_q) begin
              payload_d = shift_q;
              pr_d      = 1'b1;
            end else begin
              ce_d  = 1'b1;
              err_d = sat_inc(err_q);
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = 16'd0;
          te_d    = 1'b1;
          rbc_d   = 1'b1;
          err_d   = sat_inc(err_q);
          state_d = HUNT;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= HUNT;
      idx_q     <= 2'd0;
      shift_q   <= 32'd0;
      xor_q     <= 8'd0;
      tmo_q     <= 16'd0;
      payload_q <= 32'd0;
      pr_q      <= 1'b0;
      rbc_q     <= 1'b0;
      ce_q      <= 1'b0;
      te_q      <= 1'b0;
      err_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      xor_q     <= xor_d;
      tmo_q     <= tmo_d;
      payload_q <= payload_d;
      pr_q      <= pr_d;
      rbc_q     <= rbc_d;
      ce_q      <= ce_d;
      te_q      <= te_d;
      err_q     <= err_d;
    end
  end

  assign payload_data           = payload_q;
  assign packet_ready           = pr_q;
  assign reset_byte_count_pulse = rbc_q;
  assign checksum_error         = ce_q;
  assign timeout_error          = te_q;
  assign err_count              = err_q;

endmodule

// File: tb/tb_order_packet_assembler.sv
// Bench for order_packet_assembler: directed vector table, corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_order_packet_assembler;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int T = 8;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic [31:0] payload_data;
  logic        packet_ready, reset_byte_count_pulse, checksum_error, timeout_error;
  logic [7:0]  err_count;

  order_packet_assembler #(.SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RESET(RESET), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .payload_data(payload_data), .packet_ready(packet_ready),
    .reset_byte_count_pulse(reset_byte_count_pulse), .checksum_error(checksum_error),
    .timeout_error(timeout_error), .err_count(err_count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: frame membership, collected payload bytes, idle count
  bit          m_in;
  logic [7:0]  m_q[$];
  int          m_idle;
  logic [31:0] m_pay;
  int          m_err;
  logic        m_pr, m_rbc, m_ce, m_te;

  typedef struct {
    logic v; logic [7:0] b; logic [31:0] pay; logic [7:0] err;
    logic pr; logic rbc; logic ce; logic te;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] cur_pay;
  int cur_err;

  function automatic logic [43:0] got_vec();
    return {payload_data, err_count, packet_ready, reset_byte_count_pulse, checksum_error, timeout_error};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_in = 0; m_q.delete(); m_idle = 0; m_pay = 0; m_err = 0;
    m_pr = 0; m_rbc = 0; m_ce = 0; m_te = 0;
  endtask

  task automatic bump();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    m_pr = 0; m_rbc = 0; m_ce = 0; m_te = 0;
    if (!m_in) begin
      if (v && b == SYNC) begin m_in = 1; m_q.delete(); m_idle = 0; end
    end else if (v) begin
      m_idle = 0;
      if (m_q.size() < 4) m_q.push_back(b);
      else begin
        if (b == (m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3])) begin
          m_pay = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_pr = 1;
        end else begin
          m_ce = 1;
          bump();
        end
        m_rbc = 1;
        m_in = 0;
      end
    end else begin
      m_idle++;
      if (m_idle == T) begin m_te = 1; m_rbc = 1; bump(); m_in = 0; end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    rx_valid = v; rx_byte = b;
    @(posedge CLK);
    cyc++;
    model_step(v, b);
    #1;
    rx_valid = 0;
    chk("model", {20'd0, got_vec()}, {20'd0, m_pay, 8'(m_err), m_pr, m_rbc, m_ce, m_te});
  endtask

  task automatic reset_dut();
    RESET = 0; rx_valid = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", {20'd0, got_vec()}, 64'd0);
    RESET = 1;
    model_reset();
  endtask

  task automatic add_frame(input logic [7:0] bs[7], input int n, input bit good, input logic [31:0] newpay);
    vec_t e;
    for (int i = 0; i < n; i++) begin
      e.v = 1; e.b = bs[i]; e.pr = 0; e.rbc = 0; e.ce = 0; e.te = 0;
      if (i == n - 1) begin
        e.rbc = 1;
        if (good) begin e.pr = 1; cur_pay = newpay; end
        else begin e.ce = 1; cur_err++; end
      end
      e.pay = cur_pay; e.err = 8'(cur_err);
      tbl.push_back(e);
    end
  endtask

  task automatic send_frame(input logic [7:0] p0, p1, p2, p3, ck);
    step(1, SYNC); step(1, p0); step(1, p1); step(1, p2); step(1, p3); step(1, ck);
  endtask

  task automatic rand_gap();
    int r, n;
    r = $urandom % 10;
    n = (r < 6) ? 0 : (r < 9) ? $urandom % 3 : $urandom_range(7, 9);
    repeat (n) step(0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] pb[4];
    logic [7:0] x;

    model_reset();
    #3;
    reset_dut();

    // directed vector table
    cur_pay = 0; cur_err = 0;
    add_frame('{8'hA5, 8'h00, 8'h2A, 8'h0A, 8'h07, 8'h28, 8'h00}, 6, 0, 32'h0);
    add_frame('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00}, 6, 1, 32'h01020304);
    add_frame('{8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5}, 7, 0, 32'h0);
    add_frame('{8'hFF, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00}, 7, 1, 32'hA5A5A5A5);
    add_frame('{8'hA5, 8'h00, 8'h2A, 8'h0A, 8'h07, 8'h27, 8'h00}, 6, 1, 32'h002A0A07);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].b);
      chk("table", {20'd0, got_vec()},
          {20'd0, tbl[i].pay, tbl[i].err, tbl[i].pr, tbl[i].rbc, tbl[i].ce, tbl[i].te});
    end
    step(0, 8'h00);
    chk("pulse_width", {62'd0, packet_ready, reset_byte_count_pulse}, 64'd0);

    // timeout after exactly T idle edges
    reset_dut();
    step(1, SYNC); step(1, 8'h11); step(1, 8'h22);
    repeat (T - 1) step(0, 8'h00);
    chk("no_early_timeout", {63'd0, timeout_error}, 64'd0);
    step(0, 8'h00);
    chk("timeout_pulse", {54'd0, timeout_error, reset_byte_count_pulse, err_count}, {54'd0, 2'b11, 8'd1});
    step(0, 8'h00);
    chk("timeout_width", {63'd0, timeout_error}, 64'd0);

    // byte on the expiry edge wins
    step(1, SYNC); step(1, 8'h11); step(1, 8'h22);
    repeat (T - 1) step(0, 8'h00);
    step(1, 8'h33);
    chk("byte_beats_timeout", {55'd0, timeout_error, err_count}, {55'd0, 1'b0, 8'd1});
    step(1, 8'h44); step(1, 8'h44);
    chk("frame_after_race", {31'd0, packet_ready, payload_data}, {31'd0, 1'b1, 32'h11223344});

    // back-to-back frames with no gap
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
    chk("back_to_back", {31'd0, packet_ready, payload_data}, {31'd0, 1'b1, 32'hDEADBEEF});

    // async reset mid-frame
    step(1, SYNC); step(1, 8'h00); step(1, 8'h2A);
    #2 RESET = 0;
    #1 chk("async_reset", {20'd0, got_vec()}, 64'd0);
    model_reset();
    #3 RESET = 1;
    step(1, 8'h0A); step(1, 8'h07); step(1, 8'h27);
    chk("trailing_ignored", {31'd0, packet_ready, payload_data}, 64'd0);
    send_frame(8'h00, 8'h2A, 8'h0A, 8'h07, 8'h27);
    chk("after_reset_good", {31'd0, packet_ready, payload_data}, {31'd0, 1'b1, 32'h002A0A07});

    // randomized frames with gaps around the timeout boundary
    for (int f = 0; f < 250; f++) begin
      if ($urandom % 4 == 0) step(1, 8'($urandom));
      rand_gap();
      step(1, SYNC);
      x = 8'h00;
      for (int k = 0; k < 4; k++) begin
        pb[k] = ($urandom % 8 == 0) ? SYNC : 8'($urandom);
        x ^= pb[k];
        rand_gap();
        step(1, pb[k]);
      end
      rand_gap();
      step(1, ($urandom % 10 < 7) ? x : x ^ 8'($urandom_range(1, 255)));
    end

    // saturation
    reset_dut();
    for (int f = 0; f < 300; f++) send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h01);
    chk("err_saturate", {56'd0, err_count}, 64'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/order_packet_assembler.md
# order_packet_assembler

Receives the raw order byte stream from the UART receiver and frames it into 32-bit order words for `order_matching_engine`. Each frame is `SYNC_BYTE`, four payload bytes, and an XOR checksum. The block drives the engine's `payload_data`, `packet_ready` and `reset_byte_count_pulse` inputs directly. Corrupt or stalled frames are discarded and counted, and never reach the engine.

## Interface
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, default 1000: consecutive idle cycles, counted inside a frame, that abort the frame; legal range 2..65535.
- `CLK`  in  1  system clock; all logic is rising-edge.
- `RESET`  in  1  asynchronous, active-low reset.
- `rx_byte`  in  8  received byte, valid only with `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe; the byte is accepted on the rising edge where this is 1.
- `payload_data`  out  32  last good order word, `{flags, price, qty, order_id}`.
- `packet_ready`  out  1  one-cycle pulse: `payload_data` is new this cycle.
- `reset_byte_count_pulse`  out  1  one-cycle pulse whenever a frame terminates (good, bad checksum, or timeout).
- `checksum_error`  out  1  one-cycle pulse on checksum mismatch.
- `timeout_error`  out  1  one-cycle pulse on frame abort by timeout.
- `err_count`  out  8  saturating count of checksum and timeout errors.

## Operation
- **States:** HUNT, PAYLOAD, CHECK.
- **HUNT:**
  - An accepted byte equal to `SYNC_BYTE` moves to PAYLOAD, clears the byte index and clears the timeout counter.
  - Any other byte is dropped silently, with no error.
- **PAYLOAD:**
  - Each accepted byte is shifted into an internal 32-bit shift register, MSB first: byte 0 goes to [31:24] and byte 3 to [7:0].
  - A running XOR is updated with each byte.
  - A byte equal to `SYNC_BYTE` is data, not a resync.
  - After byte 3, move to CHECK.
- **CHECK, next accepted byte:**
  - Equal to the running XOR: copy the shift register to `payload_data`, pulse `packet_ready` and `reset_byte_count_pulse`, go to HUNT.
  - Not equal: `payload_data` is unchanged; pulse `checksum_error` and `reset_byte_count_pulse`; increment `err_count`; go to HUNT.
- **Timeout (PAYLOAD or CHECK only):**
  - The counter increments on every cycle with `rx_valid`=0 and clears on every accepted byte.
  - When it reaches `TIMEOUT_CYCLES`, go to HUNT; pulse `timeout_error` and `reset_byte_count_pulse`; increment `err_count`.
  - The counter is idle and held at 0 in HUNT.
- **Simultaneous events:**
  - A byte accepted on the same edge the counter would expire wins. The byte is processed normally and no timeout occurs.
  - A checksum error and a timeout cannot coincide.
- **`err_count`:** increments by 1 per error event and saturates at 255, with no wrap. It is cleared only by reset.
- **`payload_data` protection:** it is written only on a good frame. Bad or partial frames never alter it.
- **Outputs:** all outputs are registered.

## Timing
- **Reset values:** `RESET`=0 immediately, with no clock needed, forces:
  - state HUNT;
  - `payload_data`=0, `packet_ready`=0, `reset_byte_count_pulse`=0;
  - `checksum_error`=0, `timeout_error`=0, `err_count`=0;
  - shift register, XOR, index and timeout counter all 0.
- **Reset release:** the block is operational on the first rising edge after `RESET` returns to 1.
- **Reset mid-frame:** the partial frame is discarded with no pulse or error counted. A frame restarts only from a fresh `SYNC_BYTE`.
- **Latency:**
  - `packet_ready`, `payload_data` and `reset_byte_count_pulse` change on the same edge that accepts the checksum byte.
  - They are visible for exactly the following clock cycle; the pulses are high for exactly 1 cycle.
- **Back-to-back frames:** `rx_valid` may be 1 on every cycle. A 6-byte frame therefore yields `packet_ready` at most once every 6 cycles, and a `SYNC_BYTE` immediately after a checksum byte is accepted.
- **No backpressure:** the engine must accept `packet_ready` unconditionally.
- **Timeout edge:** with the last byte accepted at edge E and `rx_valid`=0 afterwards, the abort occurs at edge E+`TIMEOUT_CYCLES`. `timeout_error` is visible in the following cycle.

## Test plan
- **Good frame:** A5 00 2A 0A 07 27 on consecutive cycles -> `payload_data`=32'h002A0A07. `packet_ready` and `reset_byte_count_pulse` are high for 1 cycle after the 0x27 edge; no errors; `err_count`=0.
- **Bad checksum then good frame:**
  - Send A5 00 2A 0A 07 28 -> `checksum_error` 1-cycle pulse, `err_count`=1, `payload_data` still 0.
  - Then A5 01 02 03 04 04 -> `payload_data`=32'h01020304.
- **Hunt filtering:** FF A5 A5 A5 A5 A5 A5 -> garbage 0xFF ignored; payload A5A5A5A5 with checksum 00 fails, because the 7th byte is A5. Then send 00 instead as the 7th byte -> `packet_ready` with `payload_data`=32'hA5A5A5A5.
- **Timeout (TIMEOUT_CYCLES=8):**
  - Send A5 11 22, then idle -> `timeout_error` pulse on the 8th idle edge, `err_count`+1, state returns to HUNT.
  - A byte arriving on exactly the 8th idle edge -> no timeout; the frame continues.
- **Saturation:** 300 bad-checksum frames -> `err_count` sticks at 255.
- **Async reset mid-frame:** send A5 00 2A, assert `RESET` low between clock edges -> all outputs 0 immediately. After release, the trailing 0A 07 27 produce nothing; a full good frame then works.
